// File: rtl/ram_io_responder.sv
// CPU-facing byte RAM with memory-mapped UART FIFOs, cycle counter and stop flag.
// All decode is on mem_a[17:16]; 2'b11 is the I/O window, anything else hits RAM.
module ram_io_responder #(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] TX_HIGH    = (PW+1)'(FIFO_DEPTH - 2);

  logic [7:0] ram [0:(1<<RAM_AW)-1];

  logic        io_sel;
  logic        io_rd_uart, io_wr_uart, io_rd_cnt, io_wr_stop;
  logic [7:0]  rd_data;
  logic [31:0] counter, snapshot;
  logic        unused_addr_bits;

  logic [7:0]  rx_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [PW:0]   rx_count;
  logic        rx_full, rx_empty, rx_push, rx_pop;

  logic [7:0]  tx_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [PW:0]   tx_count, tx_count_next;
  logic        tx_full, tx_req, tx_push, tx_pop;

  assign unused_addr_bits = ^mem_a[31:18];

  assign io_sel     = (mem_a[17:16] == 2'b11);
  assign io_rd_uart = io_sel && !mem_wr && (mem_a[15:0] == 16'h0000);
  assign io_wr_uart = io_sel &&  mem_wr && (mem_a[15:0] == 16'h0000);
  assign io_rd_cnt  = io_sel && !mem_wr && (mem_a[15:0] == 16'h0004);
  assign io_wr_stop = io_sel &&  mem_wr && (mem_a[15:0] == 16'h0004);

  assign rx_full  = (rx_count == FULL_COUNT);
  assign rx_empty = (rx_count == '0);
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = io_rd_uart && !rx_empty;

  assign tx_full  = (tx_count == FULL_COUNT);
  assign tx_valid = (tx_count != '0);
  assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr] : '0;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_req   = io_wr_uart && (mem_dout != '0);
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign tx_push  = tx_req && (!tx_full || tx_pop);

  always_comb begin
    tx_count_next = tx_count;
    if (tx_push && !tx_pop)
      tx_count_next = tx_count + (PW+1)'(1);
    else if (!tx_push && tx_pop)
      tx_count_next = tx_count - (PW+1)'(1);
  end

  always_comb begin
    rd_data = '0;
    if (!io_sel) begin
      rd_data = ram[mem_a[RAM_AW-1:0]];
    end else begin
      case (mem_a[15:0])
        16'h0000: rd_data = rx_empty ? '0 : rx_mem[rx_rd_ptr];
        16'h0004: rd_data = counter[7:0];
        16'h0005: rd_data = snapshot[15:8];
        16'h0006: rd_data = snapshot[23:16];
        16'h0007: rd_data = snapshot[31:24];
        default:  rd_data = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; only pointers and counts define FIFO contents.
  always_ff @(posedge clk_in) begin
    if (!io_sel && mem_wr)
      ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    if (rx_push)
      rx_mem[rx_wr_ptr] <= rx_data;
    if (tx_push)
      tx_mem[tx_wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din        <= '0;
      counter        <= '0;
      snapshot       <= '0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      rx_count       <= '0;
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      tx_count       <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (!mem_wr)
        mem_din <= rd_data;
      if (io_rd_cnt)
        snapshot <= counter;
      if (io_wr_stop)
        program_stop <= 1'b1;
      if (tx_req && !tx_push)
        tx_overflow <= 1'b1;

      if (rx_push)
        rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)
        rx_rd_ptr <= rx_rd_ptr + PW'(1);
      if (rx_push && !rx_pop)
        rx_count <= rx_count + (PW+1)'(1);
      else if (!rx_push && rx_pop)
        rx_count <= rx_count - (PW+1)'(1);

      if (tx_push)
        tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)
        tx_rd_ptr <= tx_rd_ptr + PW'(1);
      tx_count       <= tx_count_next;
      io_buffer_full <= (tx_count_next >= TX_HIGH);
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM, RX/TX FIFOs, counter snapshot, stop flag, reset.
module tb_ram_io_responder;

  localparam logic [31:0] IDLE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = IDLE;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        program_stop;
  logic        tx_overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ram_io_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
    .clk_in(clk), .rst_in(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [31:0] addr, input logic [7:0] data);
    mem_a = addr; mem_wr = 1'b1; mem_dout = data;
    tick;
    mem_wr = 1'b0; mem_a = IDLE;
  endtask

  task automatic cpu_rd(input logic [31:0] addr);
    mem_a = addr; mem_wr = 1'b0;
    tick;
    mem_a = IDLE;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_din"}, 32'(mem_din), 32'h00);
    check({tag, "_io_full"}, 32'(io_buffer_full), 32'h0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'h1);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    check({tag, "_stop"}, 32'(program_stop), 32'h0);
    check({tag, "_tx_ovf"}, 32'(tx_overflow), 32'h0);
  endtask

  logic [7:0] tx_exp [8];

  initial begin
    #1;
    check_reset_outputs("por");
    tick; tick;
    rst = 1'b0;

    // Counter: edges 0..0x12344 at idle, then sample 0x30004 at counter 0x12345.
    repeat (32'h12345) tick;
    cpu_rd(32'h30004);
    check("cnt_b0", 32'(mem_din), 32'h45);
    repeat (5) tick;
    cpu_rd(32'h30005); check("cnt_b1", 32'(mem_din), 32'h23);
    cpu_rd(32'h30006); check("cnt_b2", 32'(mem_din), 32'h01);
    cpu_rd(32'h30007); check("cnt_b3", 32'(mem_din), 32'h00);

    // RAM
    cpu_rd(32'h30005);
    cpu_wr(32'h00010, 8'hA5);
    check("ram_wr_hold", 32'(mem_din), 32'h23);
    cpu_wr(32'h1FFFF, 8'h3C);
    cpu_rd(32'h00010); check("ram_rd_10", 32'(mem_din), 32'hA5);
    cpu_rd(32'h1FFFF); check("ram_rd_1ffff", 32'(mem_din), 32'h3C);
    cpu_rd(32'h20010); check("ram_alias", 32'(mem_din), 32'hA5);
    cpu_wr(32'h00020, 8'h77);
    cpu_rd(32'h00020); check("ram_raw", 32'(mem_din), 32'h77);
    cpu_wr(32'h00020, 8'h78);
    cpu_rd(32'h00020); check("ram_raw2", 32'(mem_din), 32'h78);

    // RX basic
    rx_valid = 1'b1; rx_data = 8'h41; tick;
    rx_data = 8'h42; tick;
    rx_valid = 1'b0;
    cpu_rd(32'h30000); check("rx_pop0", 32'(mem_din), 32'h41);
    cpu_rd(32'h30000); check("rx_pop1", 32'(mem_din), 32'h42);
    cpu_rd(32'h30000); check("rx_pop_empty", 32'(mem_din), 32'h00);

    // RX same-edge push and pop while empty
    rx_valid = 1'b1; rx_data = 8'h5A; mem_a = 32'h30000;
    tick;
    rx_valid = 1'b0; mem_a = IDLE;
    check("rx_simul_rd", 32'(mem_din), 32'h00);
    cpu_rd(32'h30000); check("rx_simul_kept", 32'(mem_din), 32'h5A);

    // RX full
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'h80 + i);
      tick;
    end
    check("rx_full_ready", 32'(rx_ready), 32'h0);
    rx_data = 8'h99; tick;
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cpu_rd(32'h30000);
      check($sformatf("rx_drain%0d", i), 32'(mem_din), 32'h80 + 32'(i));
    end
    cpu_rd(32'h30000); check("rx_drop_full", 32'(mem_din), 32'h00);
    check("rx_ready_after", 32'(rx_ready), 32'h1);

    // TX
    cpu_wr(32'h30000, 8'h48);
    cpu_wr(32'h30000, 8'h00);
    cpu_wr(32'h30000, 8'h49);
    check("tx_valid", 32'(tx_valid), 32'h1);
    check("tx_head", 32'(tx_data), 32'h48);
    check("tx_full_cnt2", 32'(io_buffer_full), 32'h0);
    cpu_wr(32'h30000, 8'h4A);
    cpu_wr(32'h30000, 8'h4B);
    cpu_wr(32'h30000, 8'h4C);
    check("tx_full_cnt5", 32'(io_buffer_full), 32'h0);
    cpu_wr(32'h30000, 8'h4D);
    check("tx_full_cnt6", 32'(io_buffer_full), 32'h1);
    cpu_wr(32'h30000, 8'h4E);
    cpu_wr(32'h30000, 8'h4F);
    check("tx_ovf_at8", 32'(tx_overflow), 32'h0);
    tx_ready = 1'b1;
    cpu_wr(32'h30000, 8'h50);
    tx_ready = 1'b0;
    check("tx_simul_ovf", 32'(tx_overflow), 32'h0);
    check("tx_simul_head", 32'(tx_data), 32'h49);
    cpu_wr(32'h30000, 8'hEE);
    check("tx_overflow", 32'(tx_overflow), 32'h1);
    tx_exp = '{8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50};
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_drain_v%0d", i), 32'(tx_valid), 32'h1);
      check($sformatf("tx_drain%0d", i), 32'(tx_data), 32'(tx_exp[i]));
      tick;
    end
    tx_ready = 1'b0;
    check("tx_empty", 32'(tx_valid), 32'h0);
    check("tx_empty_data", 32'(tx_data), 32'h00);
    check("tx_empty_full", 32'(io_buffer_full), 32'h0);
    check("tx_ovf_sticky", 32'(tx_overflow), 32'h1);

    // Other I/O and stop
    cpu_rd(32'h00010);
    cpu_rd(32'h30008); check("io_other_rd", 32'(mem_din), 32'h00);
    cpu_wr(32'h30001, 8'h05);
    check("io_other_wr", 32'(program_stop), 32'h0);
    cpu_wr(32'h30004, 8'h00);
    check("stop_set", 32'(program_stop), 32'h1);
    repeat (3) tick;
    check("stop_held", 32'(program_stop), 32'h1);

    // Load state, then reset between edges
    rx_valid = 1'b1; rx_data = 8'h11; tick; rx_valid = 1'b0;
    cpu_wr(32'h30000, 8'h22);
    cpu_rd(32'h00010);
    check("pre_rst_din", 32'(mem_din), 32'hA5);
    #2 rst = 1'b1;
    #1 check_reset_outputs("arst");
    tick;
    rst = 1'b0; mem_a = 32'h30004;
    tick; check("post_cnt0", 32'(mem_din), 32'h00);
    tick; check("post_cnt1", 32'(mem_din), 32'h01);
    cpu_rd(32'h30000); check("post_rx_empty", 32'(mem_din), 32'h00);
    cpu_rd(32'h00010); check("post_ram_10", 32'(mem_din), 32'hA5);
    cpu_rd(32'h1FFFF); check("post_ram_1ffff", 32'(mem_din), 32'h3C);
    check("post_tx_valid", 32'(tx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_io_responder.md
RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 The module SHALL have parameter RAM_AW, default 17, giving the byte-address width of the internal RAM (2^RAM_AW bytes).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 8 (power of two), giving the depth of each of the RX and TX FIFOs.
REQ-003 The module SHALL have ports:
  - clk_in  input  1  single clock; all state changes on its rising edge.
  - rst_in  input  1  asynchronous reset, active-high.
  - mem_a  input  32  byte address from the CPU; only bits 17:0 are decoded.
  - mem_dout  input  8  write data from the CPU.
  - mem_wr  input  1  1 = write, 0 = read.
  - mem_din  output  8  read data to the CPU.
  - io_buffer_full  output  1  TX FIFO near-full indication to the CPU.
  - rx_valid  input  1  UART receive byte valid.
  - rx_data  input  8  UART receive byte.
  - rx_ready  output  1  RX FIFO can accept a byte.
  - tx_valid  output  1  TX FIFO head valid.
  - tx_data  output  8  TX FIFO head byte.
  - tx_ready  input  1  UART transmitter accepts the head byte.
  - program_stop  output  1  sticky program-end flag.
  - tx_overflow  output  1  sticky flag: a TX push was dropped.

Function
REQ-004 Decode SHALL be: mem_a[17:16]==2'b11 selects I/O; any other value selects RAM at byte index mem_a[RAM_AW-1:0].
REQ-005 A RAM write SHALL store mem_dout at the addressed byte on the edge where mem_wr=1; single-cycle, no handshake.
REQ-006 Read latency SHALL be exactly one cycle: mem_din after edge N equals the byte selected by mem_a sampled at edge N with mem_wr=0.
REQ-007 After a write cycle, mem_din SHALL hold its previous value.
REQ-008 RAM read-after-write to the same address on the next cycle SHALL return the newly written byte.
REQ-009 I/O read of 0x30000 SHALL return the RX FIFO head and pop it on the same edge; if the RX FIFO is empty it SHALL return 0x00 and not pop.
REQ-010 The CPU-side protocol SHALL be one read cycle per 0x30000 byte; every sampled read cycle at 0x30000 is a pop.
REQ-011 I/O write of 0x30000 SHALL push mem_dout into the TX FIFO, except that 0x00 SHALL be ignored.
REQ-012 A TX push while the TX FIFO is full SHALL be dropped and SHALL set tx_overflow until reset.
REQ-013 A free-running 32-bit cycle counter SHALL increment every cycle after reset, wrapping 0xFFFFFFFF->0.
REQ-014 I/O read of 0x30004 SHALL return counter[7:0] and latch the full counter value into a 32-bit snapshot on the same edge.
REQ-015 Reads of 0x30005, 0x30006 and 0x30007 SHALL return snapshot bytes 1, 2 and 3 respectively, without relatching.
REQ-016 I/O write of 0x30004 SHALL set program_stop, which stays high until reset; the write data is ignored.
REQ-017 Reads of any other I/O address SHALL return 0x00; writes to any other I/O address SHALL have no effect.
REQ-018 RX FIFO behaviour:
  - It SHALL push rx_data when rx_valid and rx_ready are both high.
  - rx_ready SHALL equal not-full.
  - A same-edge push and pop SHALL leave the count unchanged; when empty at that edge, the pop returns 0x00 and the pushed byte is retained.
REQ-019 TX FIFO behaviour:
  - tx_valid SHALL equal not-empty, and tx_data SHALL be the head byte.
  - The head SHALL pop when tx_valid and tx_ready are both high.
  - A same-edge push and pop SHALL leave the count unchanged; when full at that edge, the push is accepted.
REQ-020 io_buffer_full SHALL be a registered output that is high when the TX count after the current edge is >= FIFO_DEPTH-2, giving margin for in-flight CPU writes.
REQ-021 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo the depth; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-022 Assertion of rst_in SHALL immediately clear the following, independent of clk_in:
  - mem_din=0x00, io_buffer_full=0, rx_ready=1, tx_valid=0, tx_data=0x00;
  - program_stop=0, tx_overflow=0;
  - counter=0, snapshot=0, both FIFOs empty.
REQ-023 RAM contents SHALL NOT be cleared by reset.
REQ-024 Reset asserted mid-operation SHALL discard FIFO contents and any pending read result; the first edge after deassertion SHALL behave as a fresh cycle with counter=0.

Verification
REQ-025 RAM: write 0xA5 to 0x00010, then 0x3C to 0x1FFFF; read each -> mem_din=0xA5 and 0x3C exactly one cycle after each read address; back-to-back read-after-write returns the new byte.
REQ-026 RX: push 0x41, 0x42 via rx_valid, then read 0x30000 three times -> 0x41, 0x42, 0x00; with FIFO full, rx_ready=0 and a further byte is not accepted.
REQ-027 TX: write 0x48, 0x00, 0x49 to 0x30000 with tx_ready=0 -> TX count 2 and tx_data=0x48; fill to 6 -> io_buffer_full=1; overfill by 1 -> tx_overflow=1; drain with tx_ready=1 -> 0x48, 0x49, ... in order.
REQ-028 Counter: read 0x30004 at counter=0x00012345, stall 5 cycles, then read 0x30005/6/7 -> 0x45, 0x23, 0x01, 0x00.
REQ-029 Stop and reset: write 0x30004 -> program_stop=1 the next cycle and held; assert rst_in asynchronously between edges -> all outputs reach REQ-022 values before the next edge, and RAM still reads back the REQ-025 data.
